tmds_channel_decoder: RTL
=========================

# tmds_channel_decoder

Receive-side counterpart of the HDMI transmitter path: recovers one TMDS channel from a stream of unaligned 10-bit words delivered by the deserializer in the `clk_pixel` domain. It finds the symbol boundary by bit-slipping until control tokens repeat, holds lock, and decodes every aligned symbol as video (8b), control (2b) and TERC4 (4b), with guard-band flags. Three instances, one per channel, feed the HDMI receive framer.

## Interface
- `CHANNEL`, 0: TMDS channel index 0..2; selects the video guard-band pattern.
- `LOCK_RUN`, 8: consecutive control tokens at one offset required to lock.
- `SEARCH_WINDOW`, 2048: cycles spent per offset while searching.
- `LOSS_TIMEOUT`, 4096: cycles without any control token before lock is dropped.

- `clk_pixel`  input  1  pixel clock; all logic on rising edge.
- `RST`  input  1  asynchronous, active-low reset.
- `raw_word`  input  10  deserialized word, bit 0 received first, unaligned.
- `locked`  output  1  alignment held; qualifies all outputs below.
- `slip_offset`  output  4  current bit offset 0..9.
- `video_data`  output  8  TMDS-decoded 8-bit value.
- `ctrl`  output  2  control bits {C1,C0} when `is_ctrl`.
- `terc4`  output  4  TERC4 value when `is_terc4`.
- `is_ctrl`, `is_terc4`, `is_video_guard`  output  1 each  symbol class flags.

## Operation
- Window: register `prev_word` <= `raw_word` each cycle; `window[19:0] = {raw_word, prev_word}`; candidate symbol `q = window[slip_offset +: 10]`.
- Control tokens (q[9:0]): 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
- Video guard band: CHANNEL 0/2 = 1011001100, CHANNEL 1 = 0100110011.
- TERC4 0..15: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- Video decode: `d = q[9] ? ~q[7:0] : q[7:0]`; `out[0]=d[0]`; for i=1..7 `out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])`. Always computed, regardless of class.
- Flags independent: one symbol may set `is_terc4` and `is_video_guard` together (TERC4 8 on CH0/2).
- FSM `SEARCH`/`LOCKED`:
  - Run counter: +1 on control token, cleared otherwise, saturating at `LOCK_RUN`.
  - SEARCH: window counter +1 per cycle. Run reaching `LOCK_RUN` -> LOCKED. Else at `SEARCH_WINDOW-1`: offset = (offset==9) ? 0 : offset+1; window and run counters cleared.
  - LOCKED: idle counter cleared on control token, else +1; at `LOSS_TIMEOUT` -> SEARCH with offset advanced (same wrap), all counters cleared.
- Counter widths `$clog2(param+1)`; no overflow possible.
- While `locked`=0: `video_data`, `ctrl`, `terc4`, all flags forced 0.

## Timing
- Reset: state SEARCH, offset 0, all counters 0, `prev_word`=0, every output 0.
- Latency: outputs registered; symbol completed by `raw_word` in cycle n appears in cycle n+1.
- `locked` rises the cycle after the `LOCK_RUN`-th consecutive token is sampled; that token's decode is the first valid output.
- Lock reached on the same cycle the search window expires: lock wins, offset unchanged.
- Offset change takes effect next cycle; the first candidate afterwards is built from `prev_word` already held (no flush).
- Loss of lock: `locked` falls the cycle after the idle counter reaches `LOSS_TIMEOUT`; outputs zero from that cycle.
- `RST` asserted mid-operation: immediate return to reset values, no partial state kept.

## Structure
- Package `tmds_pkg`: control-token, guard-band and TERC4 constant arrays, state enum `tmds_align_state_t`.
- Sub-module `tmds_symbol_decode` (combinational, 10b in -> video/ctrl/terc4/flags, `CHANNEL` param); top holds window, FSM, counters, output registers.

## Test plan
- Aligned stream of 12× token 00 then video 0x??-encoded 0x55, offset already 0 -> `locked`=1 after 9 cycles, `ctrl`=00, then `video_data`=0x55.
- Stream shifted by 3 bits, continuous token 01 -> offset steps 0,1,2,3 every 2048 cycles; lock at offset 3, `ctrl`=01.
- Locked, then 4096 cycles of video with no tokens -> `locked` falls, `slip_offset` advances by 1, outputs 0.
- TERC4 codes 0..15 on CHANNEL 0 -> `terc4` = 0..15; code 8 also sets `is_video_guard`; CHANNEL 1 code 0100110011 -> `is_video_guard`=1.
- Lock achieved on the last search-window cycle -> stays at that offset, `locked`=1.
- `RST` low mid-lock -> all outputs 0 and offset 0 immediately; relock after `LOCK_RUN` tokens.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS channel decoder.
// Contents: control-token table, video guard-band patterns, TERC4 table,
// alignment state enum and the bit-offset wrap helper.
package tmds_pkg;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } tmds_align_state_t;

    // Index is the decoded {C1,C0} value.
    localparam logic [9:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam logic [9:0] VGB_CH02 = 10'b1011001100;
    localparam logic [9:0] VGB_CH1  = 10'b0100110011;

    // Index is the decoded TERC4 nibble.
    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [3:0] OFFSET_MAX = 4'd9;

    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == OFFSET_MAX) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol.
// Ports:
//   i_sym            aligned 10-bit symbol, bit 0 first on the wire
//   o_video          TMDS-decoded 8-bit value (always computed)
//   o_ctrl           {C1,C0} when o_is_ctrl
//   o_terc4          TERC4 nibble when o_is_terc4
//   o_is_ctrl, o_is_terc4, o_is_video_guard   independent class flags
module tmds_symbol_decode
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic [9:0] i_sym,
    output logic [7:0] o_video,
    output logic [1:0] o_ctrl,
    output logic [3:0] o_terc4,
    output logic       o_is_ctrl,
    output logic       o_is_terc4,
    output logic       o_is_video_guard
);

    localparam logic [9:0] VGB = (CHANNEL == 1) ? VGB_CH1 : VGB_CH02;

    logic [7:0] w_d;

    always_comb begin
        w_d        = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
        o_video    = '0;
        o_video[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            // q[8] selects whether the encoder chained with XOR or XNOR
            o_video[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_comb begin
        o_ctrl     = '0;
        o_is_ctrl  = 1'b0;
        o_terc4    = '0;
        o_is_terc4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i_sym == CTRL_TOKEN[i]) begin
                o_is_ctrl = 1'b1;
                o_ctrl    = i[1:0];
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (i_sym == TERC4_CODE[i]) begin
                o_is_terc4 = 1'b1;
                o_terc4    = i[3:0];
            end
        end
        o_is_video_guard = (i_sym == VGB);
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit-slip word alignment on repeated control
// tokens, lock supervision, and registered symbol decode.
// Ports:
//   clk_pixel        pixel clock, rising edge
//   RST              asynchronous active-low reset
//   raw_word         unaligned deserializer word, bit 0 received first
//   locked           alignment held; qualifies all decoded outputs
//   slip_offset      current bit offset 0..9
//   video_data, ctrl, terc4, is_ctrl, is_terc4, is_video_guard
//                    decoded symbol, forced to 0 while not locked
//
// state     | meaning
// ST_SEARCH | trying one bit offset for SEARCH_WINDOW cycles, counting token runs
// ST_LOCKED | offset held; idle counter watches for token starvation
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL       = 0,
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       clk_pixel,
    input  logic       RST,
    input  logic [9:0] raw_word,
    output logic       locked,
    output logic [3:0] slip_offset,
    output logic [7:0] video_data,
    output logic [1:0] ctrl,
    output logic [3:0] terc4,
    output logic       is_ctrl,
    output logic       is_terc4,
    output logic       is_video_guard
);

    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
    localparam int IDLE_W = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_RUN);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(LOSS_TIMEOUT);

    tmds_align_state_t r_state, w_state_nxt;
    logic [9:0]        r_prev_word;
    logic [3:0]        r_offset, w_offset_nxt;
    logic [RUN_W-1:0]  r_run, w_run_nxt;
    logic [WIN_W-1:0]  r_win, w_win_nxt;
    logic [IDLE_W-1:0] r_idle, w_idle_nxt;

    logic [19:0] w_window;
    logic [9:0]  w_q;
    logic [7:0]  w_video;
    logic [1:0]  w_ctrl;
    logic [3:0]  w_terc4;
    logic        w_is_ctrl, w_is_terc4, w_is_vgb;
    logic        w_lock_nxt;

    assign w_window = {raw_word, r_prev_word};
    assign w_q      = w_window[{1'b0, r_offset} +: 10];

    tmds_symbol_decode #(.CHANNEL(CHANNEL)) u_dec (
        .i_sym            (w_q),
        .o_video          (w_video),
        .o_ctrl           (w_ctrl),
        .o_terc4          (w_terc4),
        .o_is_ctrl        (w_is_ctrl),
        .o_is_terc4       (w_is_terc4),
        .o_is_video_guard (w_is_vgb)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_win_nxt    = '0;
        w_idle_nxt   = '0;
        w_run_nxt    = w_is_ctrl ? ((r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1)) : '0;
        case (r_state)
            ST_SEARCH: begin
                w_win_nxt = r_win + WIN_W'(1);
                // A run completing on the window's last cycle still locks.
                if (w_run_nxt == RUN_MAX) begin
                    w_state_nxt = ST_LOCKED;
                    w_win_nxt   = '0;
                end else if (r_win == WIN_LAST) begin
                    w_offset_nxt = next_offset(r_offset);
                    w_win_nxt    = '0;
                    w_run_nxt    = '0;
                end
            end
            ST_LOCKED: begin
                w_idle_nxt = w_is_ctrl ? '0 : r_idle + IDLE_W'(1);
                if (w_idle_nxt == IDLE_MAX) begin
                    w_state_nxt  = ST_SEARCH;
                    w_offset_nxt = next_offset(r_offset);
                    w_idle_nxt   = '0;
                    w_run_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_run_nxt   = '0;
            end
        endcase
        w_lock_nxt = (w_state_nxt == ST_LOCKED);
    end

    always_ff @(posedge clk_pixel or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_SEARCH;
            r_prev_word <= '0;
            r_offset    <= '0;
            r_run       <= '0;
            r_win       <= '0;
            r_idle      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_word <= raw_word;
            r_offset    <= w_offset_nxt;
            r_run       <= w_run_nxt;
            r_win       <= w_win_nxt;
            r_idle      <= w_idle_nxt;
        end
    end

    // Output qualification follows the next state so the token that
    // completes the lock run is the first valid output.
    always_ff @(posedge clk_pixel or negedge RST) begin
        if (!RST) begin
            locked         <= 1'b0;
            video_data     <= '0;
            ctrl           <= '0;
            terc4          <= '0;
            is_ctrl        <= 1'b0;
            is_terc4       <= 1'b0;
            is_video_guard <= 1'b0;
        end else begin
            locked         <= w_lock_nxt;
            video_data     <= w_lock_nxt ? w_video : '0;
            ctrl           <= w_lock_nxt ? w_ctrl : '0;
            terc4          <= w_lock_nxt ? w_terc4 : '0;
            is_ctrl        <= w_lock_nxt & w_is_ctrl;
            is_terc4       <= w_lock_nxt & w_is_terc4;
            is_video_guard <= w_lock_nxt & w_is_vgb;
        end
    end

    assign slip_offset = r_offset;

endmodule
